// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the parametrised XOR stream cipher.
// The config register layout is derived from the LFSR width:
//   [2W+1] ksel    1 = use the external key bit instead of the LFSR
//   [2W]   bypass  1 = pass plaintext straight through
//   [2W-1:W] seed  LFSR reload value
//   [W-1:0]  taps  Galois feedback mask
package xor_cipher_pkg;

  function automatic int cfg_w(input int w);
    return 2 * w + 2;
  endfunction

  function automatic int ksel_bit(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int bypass_bit(input int w);
    return 2 * w;
  endfunction

  function automatic int seed_lsb(input int w);
    return w;
  endfunction

  function automatic int taps_lsb(input int w);
    return 0 * w;
  endfunction

endpackage

// File: rtl/galois_lfsr_p.sv
// Galois LFSR keystream generator with run-time taps.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   load      reload the state from seed (zero seed is replaced by 1)
//   seed      reload value
//   advance   take one Galois step
//   taps      feedback mask (zero is legal: plain shift-right)
//   state     current LFSR state
//   k         keystream bit, state[0]
module galois_lfsr_p
  import xor_cipher_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] SEED_RST = WIDTH'(32'h00000001)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             advance,
  input  logic [WIDTH-1:0] taps,
  output logic [WIDTH-1:0] state,
  output logic             k
);

  logic [WIDTH-1:0] state_q;

  // An all-zero state never leaves zero, so a zero seed is forced to 1.
  function automatic logic [WIDTH-1:0] guard_seed(input logic [WIDTH-1:0] s);
    return (s == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : s;
  endfunction

  function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] t);
    return (s >> 1) ^ (s[0] ? t : '0);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= guard_seed(SEED_RST);
    end else if (load) begin
      state_q <= guard_seed(seed);
    end else if (advance) begin
      state_q <= galois_step(state_q, taps);
    end
  end

  assign state = state_q;
  assign k     = state_q[0];

endmodule

// File: rtl/xor_stream_cipher_p.sv
// Parametrised bit-serial XOR stream cipher.
// A serial, daisy-chainable config chain loads taps, seed, bypass and ksel;
// the LFSR only steps on accepted bits so the keystream stays aligned with
// the data actually consumed.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   data_stream         plaintext bit
//   in_valid/in_ready   input handshake (bit accepted when both high)
//   external_k          external key bit, used when ksel=1
//   e                   ciphertext bit (registered)
//   d                   loopback decrypt e^k (registered)
//   out_valid           e/d valid
//   cfg_en/cfg_i/cfg_o  serial config chain, MSB (ksel) first
//   lfsr_state          current LFSR state (debug)
module xor_stream_cipher_p
  import xor_cipher_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] TAPS_RST = WIDTH'(32'h00000060),
  parameter logic [WIDTH-1:0] SEED_RST = WIDTH'(32'h00000001)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_stream,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             external_k,
  output logic             e,
  output logic             d,
  output logic             out_valid,
  input  logic             cfg_en,
  input  logic             cfg_i,
  output logic             cfg_o,
  output logic [WIDTH-1:0] lfsr_state
);

  localparam int CFG_W      = cfg_w(WIDTH);
  localparam int KSEL_BIT   = ksel_bit(WIDTH);
  localparam int BYPASS_BIT = bypass_bit(WIDTH);
  localparam int SEED_LSB   = seed_lsb(WIDTH);
  localparam int TAPS_LSB   = taps_lsb(WIDTH);

  localparam logic [CFG_W-1:0] CFG_RST = {1'b0, 1'b0, SEED_RST, TAPS_RST};

  logic [CFG_W-1:0] cfg_q;
  logic             cfg_en_q;
  logic             reload;
  logic             accept;
  logic             ksel;
  logic             bypass;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] taps;
  logic             lfsr_k;
  logic             k;
  logic             advance;
  logic             e_p1;
  logic             d_p1;
  logic             vld_p1;

  // Config chain: shifts only while cfg_en is high, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q    <= CFG_RST;
      cfg_en_q <= 1'b0;
    end else begin
      cfg_en_q <= cfg_en;
      if (cfg_en) begin
        cfg_q <= {cfg_q[CFG_W-2:0], cfg_i};
      end
    end
  end

  assign cfg_o  = cfg_q[CFG_W-1];
  assign ksel   = cfg_q[KSEL_BIT];
  assign bypass = cfg_q[BYPASS_BIT];
  assign seed   = cfg_q[SEED_LSB +: WIDTH];
  assign taps   = cfg_q[TAPS_LSB +: WIDTH];

  // Falling edge of cfg_en: the freshly shifted seed is loaded this cycle,
  // so no data may be consumed until the keystream is realigned.
  assign reload   = cfg_en_q && !cfg_en;
  assign in_ready = !cfg_en && !reload;
  assign accept   = in_valid && in_ready;
  assign advance  = accept && !ksel && !bypass;

  galois_lfsr_p #(
    .WIDTH    (WIDTH),
    .SEED_RST (SEED_RST)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (reload),
    .seed    (seed),
    .advance (advance),
    .taps    (taps),
    .state   (lfsr_state),
    .k       (lfsr_k)
  );

  assign k = ksel ? external_k : lfsr_k;

  // Stage p1: registered ciphertext and loopback decrypt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_p1   <= 1'b0;
      d_p1   <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        e_p1 <= bypass ? data_stream : (data_stream ^ k);
        d_p1 <= bypass ? data_stream : ((data_stream ^ k) ^ k);
      end
    end
  end

  assign e         = e_p1;
  assign d         = d_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_xor_stream_cipher_p.sv
module tb_xor_stream_cipher_p;

  localparam int W  = 8;
  localparam int CW = 2 * W + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         data_stream = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         external_k = 1'b0;
  logic         e;
  logic         d;
  logic         out_valid;
  logic         cfg_en = 1'b0;
  logic         cfg_i = 1'b0;
  logic         cfg_o;
  logic [W-1:0] lfsr_state;

  int total = 0;
  int bad   = 0;

  xor_stream_cipher_p #(
    .WIDTH    (W),
    .TAPS_RST (8'hB8),
    .SEED_RST (8'h01)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_stream (data_stream),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .external_k  (external_k),
    .e           (e),
    .d           (d),
    .out_valid   (out_valid),
    .cfg_en      (cfg_en),
    .cfg_i       (cfg_i),
    .cfg_o       (cfg_o),
    .lfsr_state  (lfsr_state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         do_rst;
    logic         vld;
    logic         dat;
    logic         ek;
    logic         exp_e;
    logic         exp_d;
    logic         exp_ov;
    logic [W-1:0] exp_st;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: act=%0h req=%0h", name, act, req);
    end
  endtask

  // Leaves time at posedge+1, away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  // Shift a full config word MSB first, optionally checking the old word on
  // cfg_o, then run the reload cycle with a bit offered that must be dropped.
  task automatic shift_cfg(input logic [CW-1:0] val, input logic chk_o,
                           input logic [CW-1:0] old, input logic [W-1:0] exp_seed);
    for (int i = 0; i < CW; i++) begin
      cfg_en = 1'b1;
      cfg_i  = val[CW-1-i];
      #1;
      chk("shift_in_ready", {31'd0, in_ready}, 32'd0);
      if (chk_o) chk("cfg_o_chain", {31'd0, cfg_o}, {31'd0, old[CW-1-i]});
      step();
    end
    cfg_en      = 1'b0;
    in_valid    = 1'b1;
    data_stream = 1'b1;
    #1;
    chk("reload_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("reload_drop_ov", {31'd0, out_valid}, 32'd0);
    chk("reload_state", {24'd0, lfsr_state}, {24'd0, exp_seed});
    in_valid = 1'b0;
    #1;
    chk("post_reload_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic accept_bit(input string name, input logic dat, input logic ek,
                            input logic exp_e, input logic exp_d, input logic [W-1:0] exp_st);
    in_valid    = 1'b1;
    data_stream = dat;
    external_k  = ek;
    step();
    in_valid = 1'b0;
    chk({name, "_e"}, {31'd0, e}, {31'd0, exp_e});
    chk({name, "_d"}, {31'd0, d}, {31'd0, exp_d});
    chk({name, "_ov"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_st"}, {24'd0, lfsr_state}, {24'd0, exp_st});
  endtask

  vec_t vecs[10];
  logic [CW-1:0] cfg_zero_seed;
  logic [CW-1:0] cfg_ext;
  logic [CW-1:0] cfg_byp;
  logic [2:0]    ek_seq;
  logic [2:0]    dat_seq;
  logic [4:0]    ks_seq;
  logic [W-1:0]  st_seq [5];

  initial begin
    //            rst   vld   dat   ek    e     d     ov    state
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hB8};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5C};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2E};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h17};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hB3};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hB3};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB8};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB8};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB8};
    vecs[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5C};

    cfg_zero_seed = {1'b0, 1'b0, 8'h00, 8'hB8};
    cfg_ext       = {1'b1, 1'b0, 8'h5A, 8'hB8};
    cfg_byp       = {1'b0, 1'b1, 8'h33, 8'hB8};

    // Reset state.
    step();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_e", {31'd0, e}, 32'd0);
    chk("rst_d", {31'd0, d}, 32'd0);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_cfg_o", {31'd0, cfg_o}, 32'd0);
    chk("rst_state", {24'd0, lfsr_state}, 32'h01);

    // Default keystream and stall behaviour.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_rst) pulse_rst();
      in_valid    = vecs[i].vld;
      data_stream = vecs[i].dat;
      external_k  = vecs[i].ek;
      step();
      chk($sformatf("vec%0d_e", i), {31'd0, e}, {31'd0, vecs[i].exp_e});
      chk($sformatf("vec%0d_d", i), {31'd0, d}, {31'd0, vecs[i].exp_d});
      chk($sformatf("vec%0d_ov", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_ov});
      chk($sformatf("vec%0d_st", i), {24'd0, lfsr_state}, {24'd0, vecs[i].exp_st});
    end
    in_valid = 1'b0;

    // Zero seed is guarded to 1 on reload.
    shift_cfg(cfg_zero_seed, 1'b0, '0, 8'h01);

    // Old config appears on cfg_o while the external-key config goes in.
    shift_cfg(cfg_ext, 1'b1, cfg_zero_seed, 8'h5A);

    // External key: data=1 with k=1,0,1 gives e=0,1,0; LFSR frozen.
    ek_seq = 3'b101;
    for (int i = 0; i < 3; i++) begin
      accept_bit($sformatf("ext%0d", i), 1'b1, ek_seq[2-i], ~ek_seq[2-i], 1'b1, 8'h5A);
    end

    // Bypass: e=d=data; LFSR frozen.
    shift_cfg(cfg_byp, 1'b0, '0, 8'h33);
    dat_seq = 3'b101;
    for (int i = 0; i < 3; i++) begin
      accept_bit($sformatf("byp%0d", i), dat_seq[2-i], 1'b0, dat_seq[2-i], dat_seq[2-i], 8'h33);
    end

    // Asynchronous reset after 7 config bits, asserted between clock edges.
    for (int i = 0; i < 7; i++) begin
      cfg_en = 1'b1;
      cfg_i  = 1'b1;
      step();
    end
    #3;
    rst = 1'b1;
    #1;
    chk("arst_e", {31'd0, e}, 32'd0);
    chk("arst_d", {31'd0, d}, 32'd0);
    chk("arst_ov", {31'd0, out_valid}, 32'd0);
    chk("arst_cfg_o", {31'd0, cfg_o}, 32'd0);
    chk("arst_state", {24'd0, lfsr_state}, 32'h01);
    cfg_en = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);

    ks_seq    = 5'b10001;
    st_seq[0] = 8'hB8;
    st_seq[1] = 8'h5C;
    st_seq[2] = 8'h2E;
    st_seq[3] = 8'h17;
    st_seq[4] = 8'hB3;
    for (int i = 0; i < 5; i++) begin
      accept_bit($sformatf("arst_ks%0d", i), 1'b0, 1'b0, ks_seq[4-i], 1'b0, st_seq[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xor_stream_cipher_p.md
Name: xor_stream_cipher_p

Overview:
Parametrised successor of the single-bit XOR stream cipher. A WIDTH-bit Galois LFSR generates the keystream. Taps, seed and mode are loaded at run time through a daisy-chainable serial config chain (cfg_en/cfg_i/cfg_o). A valid/ready handshake on the data stream advances the key only on accepted bits. Produces the registered ciphertext e and the loopback-decrypted d, and sits between the data source and the chip output pins.

Parameters:
WIDTH, 32, LFSR/taps/seed width (>=4)
TAPS_RST, 32'h00000060, taps value after reset
SEED_RST, 32'h00000001, seed value after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
data_stream  in  1  plaintext bit
in_valid  in  1  data_stream/external_k valid
in_ready  out  1  block accepts a bit this cycle
external_k  in  1  external key bit, used when ksel=1
e  out  1  ciphertext bit (registered)
d  out  1  loopback decrypt, e^k (registered)
out_valid  out  1  e/d valid
cfg_en  in  1  config shift enable
cfg_i  in  1  config serial in
cfg_o  out  1  config serial out (daisy chain)
lfsr_state  out  WIDTH  current LFSR state (debug)

Behaviour:
- Clock: clk only. Reset: rst, asynchronous, active-high; it dominates every other input.
- Config register, CFG_W = 2*WIDTH+2 bits: [2W+1]=ksel (1=external key), [2W]=bypass, [2W-1:W]=seed, [W-1:0]=taps.
- Config reset value: {0, 0, SEED_RST, TAPS_RST}.
- cfg_en=1: each clock, cfg <= {cfg[CFG_W-2:0], cfg_i}. cfg_o = cfg[CFG_W-1], driven from the register with no combinational path. Fields are shifted in MSB first, so ksel is the first bit shifted in. cfg holds when cfg_en=0.
- Reload: cfg_en_q is cfg_en registered. The cycle with cfg_en_q=1 and cfg_en=0 is the reload cycle: state <= seed, or 1 if seed==0 (lockup guard).
- in_ready = !cfg_en && !reload. Reset values: in_ready=1 after reset, state=SEED_RST (1 if SEED_RST==0), e=0, d=0, out_valid=0, cfg_o=TAPS_RST-independent MSB of reset cfg (0).
- Accept: accept = in_valid && in_ready.
- Key selection: k = external_k if ksel, else lfsr k = state[0].
- On accept with ksel=0 and bypass=0, Galois step: state <= (state>>1) ^ (state[0] ? taps : 0). The LFSR holds on any cycle without accept, and also when ksel=1 or bypass=1.
- Outputs, latency 1: on accept, e <= bypass ? data_stream : data_stream^k; d <= bypass ? data_stream : data_stream^k^k (=data_stream); out_valid <= 1. Otherwise out_valid <= 0, and e/d hold.
- in_valid while in_ready=0 is dropped, with no queueing. Keystream alignment after reconfig is guaranteed only by the reload.
- Zero taps: legal. The LFSR is then a shift-right register that decays to 0 and stays there; no guard applies.
- Reset mid-shift restores reset cfg and state. Partial config is discarded.
- Mode bits take effect on the first accept after reload.

Decomposition:
- Package xor_cipher_pkg: cfg field offset functions/constants (KSEL_BIT, BYPASS_BIT, SEED_LSB, TAPS_LSB as functions of WIDTH) and a CFG_W calc.
- Sub-module galois_lfsr_p #(WIDTH): ports clk, rst, load, seed, advance, taps, state, k. It carries the zero-seed guard. Top contains the config chain, handshake and output registers.

Test Plan:
- Reset and default keystream, WIDTH=8, TAPS_RST=8'hB8, SEED_RST=8'h01: after reset, accept five bits with data=0 -> e sequence 1,0,0,0,1; lfsr_state 01→B8→5C→2E→17→B3; d=0 every cycle; out_valid one cycle after each accept.
- Config shift, WIDTH=8: shift 18 bits of {0, 0, 8'h00, 8'hB8} MSB first -> in_ready=0 during shift and the reload cycle; state=8'h01 after reload (zero-seed guard). Then shift 18 more bits -> the old cfg appears bit by bit on cfg_o.
- Stall: toggle in_valid 1,0,0,1 with data=1 from seed 01 -> e=0 then e=1; state advances only twice (01→B8→5C); out_valid pattern 1,0,0,1.
- External key: cfg ksel=1, data=1, external_k=1,0,1 -> e=0,1,0; lfsr_state frozen at the seed.
- Bypass: cfg bypass=1, data 1,0,1 -> e=d=1,0,1; state frozen.
- Async reset mid-shift, asserting rst between clock edges after 7 cfg bits: outputs clear immediately; cfg returns to its reset value; the next accept yields the default keystream.
